// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron in the TinyTapeout user-project wrapper.
// Integrates ui_in into a 15-bit membrane potential with shift leak, spike and refractory hold.
module lif_neuron #(
    parameter int unsigned THRESHOLD      = 2000,
    parameter int unsigned LEAK_SHIFT     = 4,
    parameter int unsigned REFRACT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [15:0] THRESH    = 16'(THRESHOLD);
    localparam logic [3:0]  REFR_LOAD = 4'(REFRACT_CYCLES);

    logic [14:0] v_mem_q, v_mem_d;
    logic        spike_q, spike_d;
    logic [3:0]  refr_q, refr_d;

    logic [15:0] leak;
    logic [15:0] sum;

    // Valid/ready does not apply here: every enabled edge consumes ui_in and every
    // cycle the registered outputs present the state produced by the previous edge.
    always_comb begin
        leak    = {1'b0, v_mem_q >> LEAK_SHIFT};
        // 16 bits hold v_mem + 255 with no wrap.
        sum     = {1'b0, v_mem_q} - leak + {8'd0, ui_in};
        v_mem_d = v_mem_q;
        spike_d = 1'b0;
        refr_d  = refr_q;
        if (ena) begin
            if (refr_q != 4'd0) begin
                v_mem_d = '0;
                refr_d  = refr_q - 4'd1;
            end else if (sum >= THRESH) begin
                v_mem_d = '0;
                spike_d = 1'b1;
                refr_d  = REFR_LOAD;
            end else begin
                v_mem_d = sum[14:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_mem_q <= '0;
            spike_q <= 1'b0;
            refr_q  <= '0;
        end else begin
            v_mem_q <= v_mem_d;
            spike_q <= spike_d;
            refr_q  <= refr_d;
        end
    end

    assign uo_out  = {spike_q, v_mem_q[6:0]};
    assign uio_out = v_mem_q[14:7];
    assign uio_oe  = 8'hFF;

    logic unused_bits;
    assign unused_bits = ^{uio_in, sum[15]};

endmodule

// File: tb/tb_lif_neuron.sv
// Scoreboard bench for lif_neuron: driver pushes expected {uio_oe, spike, v_mem} per edge,
// monitor pops and compares after every rising edge.
module tb_lif_neuron;

    localparam int THR  = 2000;
    localparam int LSH  = 4;
    localparam int REFR = 2;
    localparam int W    = 24;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // reference model state
    int m_v    = 0;
    int m_refr = 0;
    bit m_spk  = 0;

    lif_neuron #(
        .THRESHOLD(THR),
        .LEAK_SHIFT(LSH),
        .REFRACT_CYCLES(REFR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .ui_in(ui_in),
        .uo_out(uo_out),
        .uio_in(uio_in),
        .uio_out(uio_out),
        .uio_oe(uio_oe)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] observed();
        return {uio_oe, uo_out[7], uio_out, uo_out[6:0]};
    endfunction

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got oe=%h spike=%0d v=%0d, expected oe=%h spike=%0d v=%0d",
                     name, act[23:16], act[15], act[14:0], exp[23:16], exp[15], exp[14:0]);
        end
    endfunction

    function automatic logic [W-1:0] pack(bit spk, int v);
        logic [14:0] v15;
        v15 = v[14:0];
        return {8'hFF, spk, v15};
    endfunction

    // Behavioural model: plain integer arithmetic on the neuron rules.
    function automatic void model_step(bit e, int ui);
        int s;
        if (!e) begin
            m_spk = 0;
        end else if (m_refr > 0) begin
            m_v    = 0;
            m_spk  = 0;
            m_refr = m_refr - 1;
        end else begin
            s = m_v - m_v / (2 ** LSH) + ui;
            if (s >= THR) begin
                m_v    = 0;
                m_spk  = 1;
                m_refr = REFR;
            end else begin
                m_v   = s;
                m_spk = 0;
            end
        end
    endfunction

    // driver tasks (all drive at negedge)
    task automatic apply(input bit e, input logic [7:0] ui);
        ena    = e;
        ui_in  = ui;
        uio_in = 8'($urandom_range(0, 255));
        model_step(e, int'(ui));
        exp_q.push_back(pack(m_spk, m_v));
    endtask

    task automatic step(input bit e, input logic [7:0] ui);
        @(negedge clk);
        apply(e, ui);
    endtask

    // Same as step, but the expected response is a fixed golden value.
    task automatic step_gold(input bit e, input logic [7:0] ui, input bit g_spk, input int g_v);
        @(negedge clk);
        ena    = e;
        ui_in  = ui;
        uio_in = 8'($urandom_range(0, 255));
        model_step(e, int'(ui));
        exp_q.push_back(pack(g_spk, g_v));
    endtask

    task automatic do_reset(input bit e, input logic [7:0] ui);
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'd255;
        ena   = 1'b1;
        #1;
        check("reset_async", observed(), pack(0, 0));
        @(posedge clk);
        #1;
        check("reset_hold", observed(), pack(0, 0));
        @(negedge clk);
        rst_n  = 1'b1;
        m_v    = 0;
        m_refr = 0;
        m_spk  = 0;
        apply(e, ui);
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                check("cycle", observed(), exp_q.pop_front());
            end
        end
    end

    // stimulus
    initial begin
        int golden[10] = '{255, 495, 720, 930, 1127, 1312, 1485, 1648, 1800, 1943};
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'd0;
        uio_in = 8'd0;
        #3;
        rst_n = 1'b0;
        #1;
        check("power_on_reset", observed(), pack(0, 0));

        // integrate and fire with golden values
        do_reset(1, 8'd255);
        for (int i = 1; i < 10; i++) step_gold(1, 8'd255, 0, golden[i]);
        step_gold(1, 8'd255, 1, 0);
        step_gold(1, 8'd255, 0, 0);
        step_gold(1, 8'd255, 0, 0);
        step_gold(1, 8'd255, 0, 255);
        for (int i = 15; i <= 24; i++) step(1, 8'd255);
        if (m_spk != 1) $display("bench note: model did not spike at edge 24");

        // leak decay
        do_reset(1, 8'd255);
        for (int i = 1; i < 10; i++) step(1, 8'd255);
        step_gold(1, 8'd0, 0, 1822);
        step_gold(1, 8'd0, 0, 1709);
        for (int i = 0; i < 120; i++) step(1, 8'd0);

        // subthreshold constant input
        do_reset(1, 8'd100);
        for (int i = 0; i < 500; i++) step(1, 8'd100);

        // enable gating at 720
        do_reset(1, 8'd255);
        step(1, 8'd255);
        step(1, 8'd255);
        for (int i = 0; i < 5; i++) step_gold(0, 8'($urandom_range(0, 255)), 0, 720);
        step_gold(1, 8'd255, 0, 930);

        // ena low right after a spike clears the pulse; reset during refractory
        do_reset(1, 8'd255);
        for (int i = 1; i < 11; i++) step(1, 8'd255);
        step(0, 8'd255);
        step(1, 8'd255);
        do_reset(1, 8'd255);
        for (int i = 1; i < 11; i++) step(1, 8'd255);
        // reset while spike is high
        do_reset(1, 8'd255);
        step(1, 8'd255);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            int mode;
            logic [7:0] ui;
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: ui = 8'($urandom_range(0, 255));
                1: ui = 8'($urandom_range(200, 255));
                2: ui = 8'($urandom_range(0, 20));
                default: ui = 8'($urandom_range(110, 140));
            endcase
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1'($urandom_range(0, 1)), ui);
            end else begin
                step($urandom_range(0, 9) != 0, ui);
            end
        end

        @(negedge clk);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never observed, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
